// File: rtl/clock_pkg.sv
// Shared time-of-day types and limits for the clock, alarm and display blocks.
package clock_pkg;

  localparam int         TIME_W   = 17;
  localparam logic [5:0] MAX_SEC  = 6'd59;
  localparam logic [5:0] MAX_MIN  = 6'd59;
  localparam logic [4:0] MAX_HOUR = 5'd23;

  typedef struct packed {
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
  } time_t;

  // seconds and minutes share the same 0..59 range
  function automatic logic [5:0] inc_mod60(input logic [5:0] v);
    return (v == MAX_SEC) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc_mod24(input logic [4:0] v);
    return (v == MAX_HOUR) ? 5'd0 : v + 5'd1;
  endfunction

endpackage

// File: rtl/time_keeper_if.sv
// Edit-pulse / time-word link between time_keeper (slave) and clock_mode (master).
interface time_keeper_if;
  import clock_pkg::*;

  logic [1:0] edit_btns;
  time_t      current_time;
  logic       sec_tick;

  modport master (output edit_btns, input current_time, input sec_tick);
  modport slave  (input edit_btns, output current_time, output sec_tick);
endinterface

// File: rtl/tick_generator.sv
// Prescaler: one-cycle tick when the count reaches CLK_FREQ-1.
// With SECONDS_CLEAR_ON_EDIT_EN a clear input restarts the count.
module tick_generator #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
`ifdef SECONDS_CLEAR_ON_EDIT_EN
  input  logic clear,
`endif
  output logic tick
);
  localparam int CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLK_FREQ - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
`ifdef SECONDS_CLEAR_ON_EDIT_EN
    else if (clear)
      cnt <= '0;
`endif
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/time_keeper.sv
// 24 h real-time counter with hour/minute edit pulses; edits override carries.
// Optional SECONDS_CLEAR_ON_EDIT_EN: minute edits also zero seconds and the prescaler.
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input logic          clk,
  input logic          reset,
  time_keeper_if.slave bus
);
  logic  tick, sec_tick_q;
  logic  min_edit, hour_edit;
  logic  sec_wrap, min_wrap;
  time_t now;

  assign min_edit  = bus.edit_btns[0];
  assign hour_edit = bus.edit_btns[1];

  tick_generator #(.CLK_FREQ(CLK_FREQ)) u_tick (
    .clk   (clk),
    .reset (reset),
`ifdef SECONDS_CLEAR_ON_EDIT_EN
    .clear (min_edit),
`endif
    .tick  (tick)
  );

  // A carry into a field that is being edited this cycle is dropped.
  assign sec_wrap = tick && (now.seconds == MAX_SEC);
  assign min_wrap = sec_wrap && !min_edit && (now.minutes == MAX_MIN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      now        <= '0;
      sec_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= tick;
      if (tick)
        now.seconds <= inc_mod60(now.seconds);
`ifdef SECONDS_CLEAR_ON_EDIT_EN
      if (min_edit)
        now.seconds <= '0;
`endif
      if (min_edit || sec_wrap)
        now.minutes <= inc_mod60(now.minutes);
      if (hour_edit || min_wrap)
        now.hours <= inc_mod24(now.hours);
    end
  end

  assign bus.current_time = now;
  assign bus.sec_tick     = sec_tick_q;
endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed vector table, hand-written corner sequences,
// and randomized edits checked against a field-arithmetic reference model.
module tb_time_keeper;
  import clock_pkg::*;

  localparam int F = 10;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  // reference model state
  int mh, mm, ms, mpre;
  bit mtick_q;

  time_keeper_if bus ();

  time_keeper #(.CLK_FREQ(F)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] hms(input int h, input int m, input int s);
    logic [16:0] t;
    t = {h[4:0], m[5:0], s[5:0]};
    return 32'(t);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    mh = 0; mm = 0; ms = 0; mpre = 0; mtick_q = 0;
  endtask

  // one clock edge of the specified behaviour, in plain arithmetic
  task automatic model_step(input logic [1:0] e);
    bit t, sc, mc;
    t  = (mpre == F - 1);
    mpre = (mpre + 1) % F;
    sc = 0; mc = 0;
    if (t) begin
      ms = ms + 1;
      if (ms == 60) begin ms = 0; sc = 1; end
    end
`ifdef SECONDS_CLEAR_ON_EDIT_EN
    if (e[0]) begin ms = 0; mpre = 0; end
`endif
    if (e[0]) mm = (mm + 1) % 60;
    else if (sc) begin
      mm = mm + 1;
      if (mm == 60) begin mm = 0; mc = 1; end
    end
    if (e[1] || mc) mh = (mh + 1) % 24;
    mtick_q = t;
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input logic [1:0] e);
    bus.edit_btns = e;
    @(posedge clk);
    model_step(e);
    @(negedge clk);
    bus.edit_btns = 2'b00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.edit_btns = 2'b00;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Leaves the DUT at h:m:s with the prescaler just restarted at 0.
  task automatic set_time(input int h, input int m, input int s);
    int n, guard;
    do_reset();
    n = (h > m) ? h : m;
    for (int i = 0; i < n; i++) step({i < h, i < m});
    guard = 0;
    while (ms != s && guard < 1000) begin step(2'b00); guard++; end
    chk("setup_time", 32'(bus.current_time), hms(h, m, s));
  endtask

  typedef struct {
    int         h0, m0, s0;
    logic [1:0] e;
    bit         tk;
    int         reps;
    int         eh, em, es, es_clr;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int pulses, cnt, es;
    bit prev, wide;
    logic [1:0] re;

    bus.edit_btns = 2'b00;
    model_reset();

    tbl[0] = '{23, 59, 59, 2'b00, 1'b1, 1,  0,  0,  0,  0};
    tbl[1] = '{ 9, 59, 59, 2'b00, 1'b1, 1, 10,  0,  0,  0};
    tbl[2] = '{10, 59, 59, 2'b01, 1'b1, 1, 10,  0,  0,  0};
    tbl[3] = '{12, 34, 56, 2'b11, 1'b0, 1, 13, 35, 56,  0};
    tbl[4] = '{23, 10, 40, 2'b10, 1'b0, 1,  0, 10, 40, 40};
    tbl[5] = '{ 5, 58, 30, 2'b01, 1'b0, 2,  5,  0, 30,  0};
    tbl[6] = '{ 8, 20, 37, 2'b01, 1'b0, 1,  8, 21, 37,  0};
    tbl[7] = '{23, 59, 58, 2'b10, 1'b1, 1,  0, 59, 59, 59};
    tbl[8] = '{22, 59, 59, 2'b10, 1'b1, 1, 23,  0,  0,  0};
    tbl[9] = '{14, 27, 33, 2'b00, 1'b1, 1, 14, 27, 34, 34};

    // reset state and free-running count
    @(negedge clk);
    chk("reset_time", 32'(bus.current_time), 32'd0);
    chk("reset_tick", 32'(bus.sec_tick), 32'd0);
    do_reset();
    pulses = 0; prev = 0; wide = 0;
    for (int i = 0; i < 100; i++) begin
      step(2'b00);
      if (bus.sec_tick) pulses++;
      if (bus.sec_tick && prev) wide = 1;
      prev = bus.sec_tick;
    end
    chk("count_pulses", 32'(pulses), 32'd10);
    chk("count_pulse_width", 32'(wide), 32'd0);
    chk("count_time", 32'(bus.current_time), hms(0, 0, 10));

    // directed vectors
    foreach (tbl[i]) begin
      set_time(tbl[i].h0, tbl[i].m0, tbl[i].s0);
      if (tbl[i].tk) repeat (F - 1) step(2'b00);
      repeat (tbl[i].reps) step(tbl[i].e);
`ifdef SECONDS_CLEAR_ON_EDIT_EN
      es = tbl[i].es_clr;
`else
      es = tbl[i].es;
`endif
      chk($sformatf("vec%0d_time", i), 32'(bus.current_time), hms(tbl[i].eh, tbl[i].em, es));
      chk($sformatf("vec%0d_sec_tick", i), 32'(bus.sec_tick), 32'(tbl[i].tk));
    end

    // asynchronous reset between edges, then first tick latency
    set_time(7, 15, 42);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_time", 32'(bus.current_time), 32'd0);
    chk("async_reset_tick", 32'(bus.sec_tick), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    do begin step(2'b00); cnt++; end while (!bus.sec_tick && cnt < 50);
    chk("async_first_tick_cycles", 32'(cnt), 32'(F));

    // minute edit effect on the prescaler phase
    set_time(8, 20, 37);
    step(2'b01);
    cnt = 0;
    do begin step(2'b00); cnt++; end while (!bus.sec_tick && cnt < 50);
`ifdef SECONDS_CLEAR_ON_EDIT_EN
    chk("edit_tick_cycles", 32'(cnt), 32'(F));
    chk("edit_time", 32'(bus.current_time), hms(8, 21, 1));
`else
    chk("edit_tick_cycles", 32'(cnt), 32'(F - 1));
    chk("edit_time", 32'(bus.current_time), hms(8, 21, 38));
`endif

    // randomized edits across wrap boundaries vs. reference model
    set_time(23, 58, 40);
    for (int i = 0; i < 3000; i++) begin
      re = {($urandom % 8) == 0, ($urandom % 8) == 0};
      step(re);
      chk("rand_time", 32'(bus.current_time), hms(mh, mm, ms));
      chk("rand_sec_tick", 32'(bus.sec_tick), 32'(mtick_q));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
